// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage controller: FSM states,
// AccessSize encodings, byte-enable patterns and store-lane helpers.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2,
      DONE     = 2'd3
   } state_e;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;

   // Reserved size 2'b11 falls through to the word pattern.
   function automatic logic [3:0] store_byte_en(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
      logic [3:0] be;
      case (size)
         SIZE_HALF: be = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
         SIZE_BYTE: be = BE_BYTE0 << addr_lo;
         default:   be = BE_WORD;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                               input logic [31:0] wdata);
      logic [31:0] lanes;
      case (size)
         SIZE_HALF: lanes = {2{wdata[15:0]}};
         SIZE_BYTE: lanes = {4{wdata[7:0]}};
         default:   lanes = wdata;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a returned memory word and
// sign- or zero-extends it to 32 bits; word accesses pass straight through.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] data_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo_i)
         2'd1:    byte_sel = data_i[15:8];
         2'd2:    byte_sel = data_i[23:16];
         2'd3:    byte_sel = data_i[31:24];
         default: byte_sel = data_i[7:0];
      endcase
      half_sel = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];

      case (size_i)
         SIZE_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
         SIZE_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
         default:   data_o = data_i;
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns EX/MEM load/store requests into a stalled
// valid/ready memory transaction. Optional macro: MEM_MISALIGN_CHECK_EN.
module mem_stage_ctrl
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int ADDR_W         = 32
)
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] Address,
   input  logic [31:0]       WriteData,
   input  logic [1:0]        AccessSize,
   input  logic              LoadSigned,
   output logic [31:0]       ReadData,
   output logic              MemStall,
   output logic              MemError,
   output logic              MReqValid,
   input  logic              MReqReady,
   output logic              MReqWrite,
   output logic [ADDR_W-1:0] MReqAddr,
   output logic [31:0]       MReqWData,
   output logic [3:0]        MReqByteEn,
   input  logic              MRspValid,
   input  logic [31:0]       MRspData,
   output logic [1:0]        DbgState
);

   // Handshake: a request transfers on a rising edge where MReqValid and
   // MReqReady are both high; MReq* are registered and stay frozen while
   // MReqValid waits for MReqReady. MRspValid has no back-pressure and is only
   // honoured in WAIT_RSP, so stray or post-reset responses are dropped.

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e            state_q,     state_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [31:0]       rdata_q,     rdata_d;
   logic              err_q,       err_d;
   logic [1:0]        addr_lo_q,   addr_lo_d;
   logic [1:0]        size_q,      size_d;
   logic              signed_q,    signed_d;
   logic              req_write_q, req_write_d;
   logic [ADDR_W-1:0] req_addr_q,  req_addr_d;
   logic [31:0]       req_wdata_q, req_wdata_d;
   logic [3:0]        req_be_q,    req_be_d;

   logic              stall;
   logic              misaligned;
   logic [31:0]       aligned_data;

   load_align u_load_align (
      .data_i    (MRspData),
      .addr_lo_i (addr_lo_q),
      .size_i    (size_q),
      .signed_i  (signed_q),
      .data_o    (aligned_data)
   );

`ifdef MEM_MISALIGN_CHECK_EN
   // Reserved size 2'b11 behaves as a word, so it shares the word rule.
   assign misaligned = ((AccessSize != SIZE_HALF) && (AccessSize != SIZE_BYTE) &&
                        (Address[1:0] != 2'b00)) ||
                       ((AccessSize == SIZE_HALF) && Address[0]);
`else
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         addr_lo_q   <= '0;
         size_q      <= '0;
         signed_q    <= 1'b0;
         req_write_q <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_be_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         addr_lo_q   <= addr_lo_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         req_write_q <= req_write_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_be_q    <= req_be_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      addr_lo_d   = addr_lo_q;
      size_d      = size_q;
      signed_d    = signed_q;
      req_write_d = req_write_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_be_d    = req_be_q;
      stall       = 1'b0;

      case (state_q)
         IDLE: begin
            if (MemRead | MemWrite) begin
               stall       = 1'b1;
               addr_lo_d   = Address[1:0];
               size_d      = AccessSize;
               signed_d    = LoadSigned;
               req_write_d = MemWrite;
               req_addr_d  = {Address[ADDR_W-1:2], 2'b00};
               req_wdata_d = store_lanes(AccessSize, WriteData);
               req_be_d    = store_byte_en(AccessSize, Address[1:0]);
               cnt_d       = '0;
               if (misaligned) begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  // Read+write together proceeds as a write but reports an error.
                  state_d = REQ;
                  err_d   = MemRead & MemWrite;
               end
            end
         end
         REQ: begin
            stall = 1'b1;
            if (MReqReady) begin
               state_d = req_write_q ? DONE : WAIT_RSP;
               cnt_d   = '0;
            end
         end
         WAIT_RSP: begin
            stall = 1'b1;
            if (MRspValid) begin
               rdata_d = aligned_data;
               cnt_d   = '0;
               state_d = DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ReadData   = rdata_q;
   assign MemStall   = stall;
   assign MemError   = (state_q == DONE) & err_q;
   assign MReqValid  = (state_q == REQ);
   assign MReqWrite  = req_write_q;
   assign MReqAddr   = req_addr_q;
   assign MReqWData  = req_wdata_q;
   assign MReqByteEn = req_be_q;
   assign DbgState   = state_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed vector table, reset during
// an access, and randomized accesses against a behavioural model.
module tb_mem_stage_ctrl;
   import mem_stage_pkg::*;

   localparam int T = 8;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        MemRead, MemWrite;
   logic [31:0] Address, WriteData;
   logic [1:0]  AccessSize;
   logic        LoadSigned;
   logic [31:0] ReadData;
   logic        MemStall, MemError;
   logic        MReqValid, MReqReady, MReqWrite;
   logic [31:0] MReqAddr, MReqWData;
   logic [3:0]  MReqByteEn;
   logic        MRspValid;
   logic [31:0] MRspData;
   logic [1:0]  DbgState;

   mem_stage_ctrl #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
      .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .WriteData(WriteData), .AccessSize(AccessSize),
      .LoadSigned(LoadSigned), .ReadData(ReadData), .MemStall(MemStall),
      .MemError(MemError), .MReqValid(MReqValid), .MReqReady(MReqReady),
      .MReqWrite(MReqWrite), .MReqAddr(MReqAddr), .MReqWData(MReqWData),
      .MReqByteEn(MReqByteEn), .MRspValid(MRspValid), .MRspData(MRspData),
      .DbgState(DbgState)
   );

   // ---------------- clock / watchdog ----------------
   always #5 Clk = ~Clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1);
   end

   // ---------------- types ----------------
   typedef struct {
      logic        rd, wr;
      logic [31:0] addr, wdata;
      logic [1:0]  size;
      logic        lsigned;
      int          ready_dly, rsp_dly;
      logic [31:0] rsp_data;
   } acc_t;

   typedef struct {
      logic [31:0] rdata, wdata, addr;
      logic [3:0]  be;
      int          stall, req;
      logic        err;
   } exp_t;

   typedef struct {
      int          stall, req_cyc, err_cyc;
      bit          done, stable, err_at_done;
      logic [31:0] addr, wdata, rdata;
      logic [3:0]  be;
      logic        wr;
   } res_t;

   typedef struct {
      acc_t a;
      exp_t e;
   } vec_t;

   // ---------------- scoreboard state ----------------
   int          n_pass   = 0;
   int          n_checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_rdata;
   vec_t        tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, ".ReadData"},   ReadData,   32'h0);
      check({tag, ".MemStall"},   MemStall,   32'h0);
      check({tag, ".MemError"},   MemError,   32'h0);
      check({tag, ".MReqValid"},  MReqValid,  32'h0);
      check({tag, ".MReqWrite"},  MReqWrite,  32'h0);
      check({tag, ".MReqAddr"},   MReqAddr,   32'h0);
      check({tag, ".MReqWData"},  MReqWData,  32'h0);
      check({tag, ".MReqByteEn"}, MReqByteEn, 32'h0);
      check({tag, ".state"},      DbgState,   IDLE);
   endtask

   // ---------------- reference model ----------------
   function automatic exp_t model(input acc_t a, input logic [31:0] prev);
      exp_t        e;
      int          n, lane;
      bit          bad;
      logic [31:0] w, mask;
      n    = (a.size == 2'b01) ? 2 : (a.size == 2'b10) ? 1 : 4;
      lane = (int'(a.addr[1:0]) / n) * n;
      bad  = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      bad  = (int'(a.addr[1:0]) % n) != 0;
`endif
      e.addr = a.addr - (a.addr % 4);
      e.be   = 4'(((1 << n) - 1) << lane);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = a.wdata[8*(i % n) +: 8];
      if (bad) begin
         e.req = 0; e.stall = 1; e.err = 1'b1; e.rdata = 32'h0;
      end else if (a.wr) begin
         e.req = a.ready_dly + 1; e.stall = 1 + e.req; e.err = a.rd; e.rdata = prev;
      end else begin
         e.req   = a.ready_dly + 1;
         e.err   = (a.rsp_dly >= T);
         e.stall = 1 + e.req + (e.err ? T : a.rsp_dly + 1);
         mask    = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
         w       = a.rsp_data >> (8*lane);
         e.rdata = w & mask;
         if (a.lsigned && n < 4 && e.rdata[8*n-1]) e.rdata = e.rdata | ~mask;
         if (e.err) e.rdata = 32'h0;
      end
      return e;
   endfunction

   // ---------------- driver / monitor ----------------
   // Entered just after a rising edge; returns just after a rising edge.
   task automatic run_access(input acc_t a, output res_t r);
      int since;
      bit acc;
      r.stall = 0; r.req_cyc = 0; r.err_cyc = 0; r.done = 0; r.stable = 1;
      r.err_at_done = 0; r.addr = '0; r.wdata = '0; r.rdata = '0; r.be = '0; r.wr = 0;
      MemRead = a.rd; MemWrite = a.wr; Address = a.addr; WriteData = a.wdata;
      AccessSize = a.size; LoadSigned = a.lsigned;
      acc = 0; since = 0;
      for (int cyc = 0; cyc < 100 && !r.done; cyc++) begin
         MReqReady = (r.req_cyc >= a.ready_dly);
         MRspValid = acc && !r.wr && (since == a.rsp_dly);
         MRspData  = MRspValid ? a.rsp_data : $urandom;
         @(negedge Clk);
         if (MemError) r.err_cyc++;
         if (acc) since++;
         if (MReqValid) begin
            if (r.req_cyc == 0) begin
               r.addr = MReqAddr; r.wdata = MReqWData; r.be = MReqByteEn; r.wr = MReqWrite;
            end else if (MReqAddr !== r.addr || MReqWData !== r.wdata ||
                         MReqByteEn !== r.be || MReqWrite !== r.wr) begin
               r.stable = 0;
            end
            r.req_cyc++;
            if (MReqReady) begin acc = 1; since = 0; end
         end
         if (MemStall) r.stall++;
         else begin
            r.done = 1; r.rdata = ReadData; r.err_at_done = MemError;
         end
         @(posedge Clk); #1;
      end
      MemRead = 0; MemWrite = 0; MReqReady = 0; MRspValid = 0;
      @(negedge Clk);
      if (MemError) r.err_cyc++;
      if (MemStall) r.stall++;
      @(posedge Clk); #1;
   endtask

   task automatic compare(input string tag, input acc_t a, input res_t r, input exp_t e);
      logic [31:0] x;
      check({tag, ".done"},     r.done,        32'd1);
      check({tag, ".stall"},    r.stall,       e.stall);
      check({tag, ".req_cyc"},  r.req_cyc,     e.req);
      check({tag, ".err_cyc"},  r.err_cyc,     {31'd0, e.err});
      check({tag, ".err_done"}, r.err_at_done, {31'd0, e.err});
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s.rdata: scoreboard empty, required an entry", tag);
      end else begin
         x = exp_q.pop_front();
         check({tag, ".rdata"}, r.rdata, x);
      end
      if (e.req > 0) begin
         check({tag, ".addr"},   r.addr,   e.addr);
         check({tag, ".be"},     r.be,     e.be);
         check({tag, ".wdata"},  r.wdata,  e.wdata);
         check({tag, ".wr"},     r.wr,     a.wr);
         check({tag, ".stable"}, r.stable, 32'd1);
      end
   endtask

   task automatic add_vec(input logic rd, wr, input logic [31:0] addr, wdata,
                          input logic [1:0] size, input logic sgn, input int rdy, rsp,
                          input logic [31:0] rsp_data, x_rdata, input logic [3:0] x_be,
                          input logic [31:0] x_wdata, x_addr, input int x_stall, x_req,
                          input logic x_err);
      vec_t v;
      v.a = '{rd, wr, addr, wdata, size, sgn, rdy, rsp, rsp_data};
      v.e = '{x_rdata, x_wdata, x_addr, x_be, x_stall, x_req, x_err};
      tbl.push_back(v);
   endtask

   task automatic reset_mid_access();
      MemRead = 1; MemWrite = 0; Address = 32'h200; WriteData = 0;
      AccessSize = SIZE_WORD; LoadSigned = 0; MReqReady = 1; MRspValid = 0;
      @(negedge Clk); check("rstseq.idle_stall", MemStall, 32'd1);
      @(posedge Clk); #1;
      @(negedge Clk); check("rstseq.req_valid", MReqValid, 32'd1);
      @(posedge Clk); #1;
      MReqReady = 0;
      @(posedge Clk); #1;
      @(negedge Clk); check("rstseq.wait_stall", MemStall, 32'd1);
      #2 Reset = 0; MemRead = 0;
      #1 check_outputs_zero("rstseq.in_rst");
      repeat (2) @(posedge Clk);
      @(negedge Clk); Reset = 1;
      @(posedge Clk); #1; MRspValid = 1; MRspData = 32'hFFFF_0001;
      @(negedge Clk);
      check("rstseq.late_stall", MemStall, 32'd0);
      check("rstseq.late_state", DbgState, IDLE);
      @(posedge Clk); #1; MRspValid = 0;
      @(negedge Clk); check_outputs_zero("rstseq.after_rsp");
      @(posedge Clk); #1;
      last_rdata = 32'h0;
   endtask

   // ---------------- test ----------------
   initial begin
      res_t r;
      exp_t e;
      acc_t a;
      int   op;
      Reset = 0; MemRead = 0; MemWrite = 0; Address = 0; WriteData = 0;
      AccessSize = 0; LoadSigned = 0; MReqReady = 0; MRspValid = 0; MRspData = 0;
      last_rdata = 32'h0;

      repeat (2) @(negedge Clk);
      check_outputs_zero("rst");
      Reset = 1;
      @(posedge Clk); #1;
      @(negedge Clk); check_outputs_zero("post_rst");
      @(posedge Clk); #1;

      //       rd wr addr          wdata         sz    s rdy rsp  rsp_data      | rdata         be       wdata         addr          st rq er
      add_vec(1, 0, 32'h100, 32'h1234_5678, 2'b00, 0, 0, 0,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 32'h1234_5678, 32'h100, 3, 1, 0);
      add_vec(1, 0, 32'h103, 32'h0,         2'b10, 1, 0, 0,   32'h80FF_1234, 32'hFFFF_FF80, 4'b1000, 32'h0,         32'h100, 3, 1, 0);
      add_vec(1, 0, 32'h103, 32'h0,         2'b10, 0, 0, 0,   32'h80FF_1234, 32'h0000_0080, 4'b1000, 32'h0,         32'h100, 3, 1, 0);
      add_vec(0, 1, 32'h22,  32'h0000_ABCD, 2'b01, 0, 4, 0,   32'h0,         32'h0000_0080, 4'b1100, 32'hABCD_ABCD, 32'h20,  6, 5, 0);
      add_vec(1, 0, 32'h40,  32'h0,         2'b00, 0, 0, 200, 32'h0,         32'h0,         4'b1111, 32'h0,         32'h40, 10, 1, 1);
      add_vec(1, 1, 32'h8,   32'h0000_005A, 2'b10, 0, 0, 0,   32'h0,         32'h0,         4'b0001, 32'h5A5A_5A5A, 32'h8,   2, 1, 1);
      add_vec(1, 0, 32'h102, 32'h0,         2'b01, 1, 0, 0,   32'h80FF_1234, 32'hFFFF_80FF, 4'b1100, 32'h0,         32'h100, 3, 1, 0);
      add_vec(1, 0, 32'h41,  32'h0,         2'b10, 0, 2, 3,   32'h0000_A500, 32'h0000_00A5, 4'b0010, 32'h0,         32'h40,  8, 3, 0);
      add_vec(1, 0, 32'h44,  32'h0,         2'b11, 0, 0, 0,   32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 32'h0,         32'h44,  3, 1, 0);
      add_vec(0, 1, 32'h7,   32'h1234_56C3, 2'b10, 0, 1, 0,   32'h0,         32'hCAFE_F00D, 4'b1000, 32'hC3C3_C3C3, 32'h4,   3, 2, 0);
`ifdef MEM_MISALIGN_CHECK_EN
      add_vec(1, 0, 32'h101, 32'h0,         2'b00, 0, 0, 0,   32'h1122_3344, 32'h0,         4'b1111, 32'h0,         32'h100, 1, 0, 1);
      add_vec(1, 0, 32'h23,  32'h0,         2'b01, 0, 0, 0,   32'hBEEF_0000, 32'h0,         4'b1100, 32'h0,         32'h20,  1, 0, 1);
`else
      add_vec(1, 0, 32'h101, 32'h0,         2'b00, 0, 0, 0,   32'h1122_3344, 32'h1122_3344, 4'b1111, 32'h0,         32'h100, 3, 1, 0);
      add_vec(1, 0, 32'h23,  32'h0,         2'b01, 0, 0, 0,   32'hBEEF_0000, 32'h0000_BEEF, 4'b1100, 32'h0,         32'h20,  3, 1, 0);
`endif

      for (int i = 0; i < tbl.size(); i++) begin
         exp_q.push_back(tbl[i].e.rdata);
         run_access(tbl[i].a, r);
         compare($sformatf("vec%0d", i), tbl[i].a, r, tbl[i].e);
         last_rdata = tbl[i].e.rdata;
      end

      reset_mid_access();

      MemRead = 0; MemWrite = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("noacc.stall", MemStall, 32'd0);
         check("noacc.valid", MReqValid, 32'd0);
         @(posedge Clk); #1;
      end

      for (int k = 0; k < 40; k++) begin
         op          = $urandom_range(0, 5);
         a.rd        = (op <= 2) || (op == 5);
         a.wr        = (op >= 3);
         a.addr      = $urandom;
         a.wdata     = $urandom;
         a.size      = 2'($urandom_range(0, 3));
         a.lsigned   = 1'($urandom_range(0, 1));
         a.ready_dly = $urandom_range(0, 3);
         a.rsp_dly   = $urandom_range(0, 9);
         a.rsp_data  = $urandom;
         e = model(a, last_rdata);
         exp_q.push_back(e.rdata);
         run_access(a, r);
         compare($sformatf("rnd%0d", k), a, r, e);
         last_rdata = e.rdata;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage controller between the EX/MEM pipeline register and a multi-cycle data memory port. It replaces the single-cycle DataMemory access with a valid/ready request and response handshake. It stalls the pipeline while an access is in flight. It also performs byte/halfword lane selection, sign or zero extension, and byte-enable generation, so MEM/WB receives load data that is already aligned.

Parameters:
TIMEOUT_CYCLES, 64, cycles to wait in WAIT_RSP for a response before aborting with an error
ADDR_W, 32, address width

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
MemRead  in  1  load request from EX/MEM
MemWrite  in  1  store request from EX/MEM
Address  in  ADDR_W  byte address (ALU result)
WriteData  in  32  store data (rt value)
AccessSize  in  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word)
LoadSigned  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
ReadData  out  32  aligned, extended load result for MEM/WB
MemStall  out  1  hold PC, IF/ID, ID/EX and EX/MEM; insert bubble into MEM/WB
MemError  out  1  one-cycle pulse flagging a failed access
MReqValid  out  1  memory request valid
MReqReady  in  1  memory accepts the request
MReqWrite  out  1  1 = write, 0 = read
MReqAddr  out  ADDR_W  word-aligned address ({Address[ADDR_W-1:2],2'b00})
MReqWData  out  32  lane-replicated store data
MReqByteEn  out  4  byte enables, bit i covers bits [8i+7:8i]
MRspValid  in  1  read data valid
MRspData  in  32  read data word

Behaviour:
- States: IDLE, REQ, WAIT_RSP, DONE.
- Reset (asynchronous, Reset=0): state=IDLE; ReadData=0, MemStall=0, MemError=0, MReqValid=0, MReqWrite=0, MReqAddr=0, MReqWData=0, MReqByteEn=0; timeout counter=0.
- Reset asserted mid-access: the in-flight request is dropped, MReqValid falls immediately, and a late MRspValid after reset is ignored.
- IDLE:
  - MemRead|MemWrite=1 drives MemStall=1 combinationally in the same cycle.
  - The next edge latches Address, WriteData, AccessSize, LoadSigned and the direction, then moves to REQ.
  - With both MemRead and MemWrite set, the access is treated as a write and MemError pulses in DONE.
- REQ:
  - MReqValid=1 and MemStall=1. All MReq* outputs stay stable until MReqValid&MReqReady.
  - A write that is accepted goes to DONE (posted write).
  - A read that is accepted goes to WAIT_RSP.
- WAIT_RSP:
  - MemStall=1; the counter increments each cycle.
  - On MRspValid: capture the aligned and extended data into ReadData, then go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 without a response: ReadData=0, MemError pulses in DONE, go to DONE.
- DONE:
  - MemStall=0 for exactly one cycle, so the pipeline advances on this edge.
  - ReadData is valid this cycle; return to IDLE.
  - The instruction that follows is therefore sampled fresh in IDLE and is never double-issued.
- Latency:
  - Write: 3 cycles when MReqReady is already high.
  - Read: 3 cycles + memory latency.
  - No access: 0 cycles, MemStall=0.
- Byte enables (little-endian):
  - Word: 1111.
  - Halfword: Address[1]=0 gives 0011, Address[1]=1 gives 1100.
  - Byte: 0001<<Address[1:0].
- Write data: MReqWData replicates the halfword twice or the byte four times.
- Load extraction:
  - Byte lane = Address[1:0].
  - Halfword = Address[1] ? [31:16] : [15:0].
  - Extend to 32 bits per LoadSigned.
- MemError: high only in the DONE cycle of a failed access; 0 otherwise.
- ReadData: holds its value until the next DONE.

Optional Feature:
MEM_MISALIGN_CHECK_EN
- Defined:
  - A word access with Address[1:0]!=0, or a halfword access with Address[0]=1, issues no memory request.
  - IDLE goes to DONE with MemError=1 and ReadData=0 (one stall cycle).
- Undefined: the low address bits below the access size are ignored, and the access proceeds as if aligned.

Decomposition:
- Package mem_stage_pkg holds:
  - the state enum (IDLE/REQ/WAIT_RSP/DONE);
  - the AccessSize encodings (SIZE_WORD, SIZE_HALF, SIZE_BYTE);
  - the byte-enable constants.
- One combinational sub-module, load_align, takes (MRspData, Address[1:0], AccessSize, LoadSigned) and produces the 32-bit result.
- The FSM, counter and store-lane logic stay in mem_stage_ctrl.

Test Plan:
- Word read: Address=0x100, MRspData=0xDEADBEEF one cycle after accept, MReqReady=1 -> MReqAddr=0x100, MReqByteEn=1111; ReadData=0xDEADBEEF in DONE; MemStall high exactly 3 cycles.
- Signed byte read: Address=0x103, MRspData=0x80FF1234, LoadSigned=1 -> ReadData=0xFFFFFF80. With LoadSigned=0 -> 0x00000080.
- Halfword store: Address=0x22, WriteData=0x0000ABCD, MReqReady held 0 for 4 cycles -> MReqWData=0xABCDABCD, MReqByteEn=1100, both stable for all 5 REQ cycles; DONE one cycle after accept.
- Timeout: TIMEOUT_CYCLES=8, read accepted, MRspValid never asserted -> DONE after 8 WAIT_RSP cycles; MemError pulses 1 cycle; ReadData=0.
- Reset in WAIT_RSP: Reset=0 for 2 cycles, then MRspValid=1 -> all outputs zero, state IDLE, response ignored, MemStall=0.
- With MEM_MISALIGN_CHECK_EN: word read at Address=0x101 -> MReqValid never asserted; MemError=1 on the next cycle. Without the macro -> request issued with MReqAddr=0x100.
